// File: rtl/fetch_unit.sv
// Fetch stage: holds the architectural PC, issues one instruction-memory
// request at a time, presents the fetched word to decode and squashes
// wrong-path fetches whenever execute redirects control flow.
module fetch_unit #(
   parameter int unsigned     AWIDTH   = 32,
   parameter int unsigned     DWIDTH   = 32,
   parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000,
   parameter logic [DWIDTH-1:0] NOP      = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              brtaken_i,
   input  logic              jump_i,
   input  logic [AWIDTH-1:0] target_i,
   input  logic              stall_i,
   output logic              imem_req_valid_o,
   output logic [AWIDTH-1:0] imem_req_addr_o,
   input  logic              imem_req_ready_i,
   input  logic              imem_rsp_valid_i,
   input  logic [DWIDTH-1:0] imem_rsp_data_i,
   output logic [AWIDTH-1:0] pc_o,
   output logic [DWIDTH-1:0] insn_o,
   output logic              valid_o,
   output logic              flush_o,
   output logic              misalign_o
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t            r_state;
   logic [AWIDTH-1:0] r_pc;
   logic              r_drop;
   logic [DWIDTH-1:0] r_insn;
   logic [AWIDTH-1:0] r_pcout;
   logic              r_valid;
   logic              r_flush;
   logic              r_misalign;

   logic              w_redirect;
   logic [AWIDTH-1:0] w_target_aligned;
   logic              w_target_misaligned;

   assign w_redirect          = brtaken_i | jump_i;
   assign w_target_aligned    = {target_i[AWIDTH-1:2], 2'b00};
   assign w_target_misaligned = (target_i[1:0] != 2'b00);

   // Request channel decodes straight from state so the address is visible in the REQ cycle itself.
   assign imem_req_valid_o = (r_state == S_REQ) && !reset;
   assign imem_req_addr_o  = r_pc;

   assign pc_o       = r_pcout;
   assign insn_o     = r_insn;
   assign valid_o    = r_valid;
   assign flush_o    = r_flush;
   assign misalign_o = r_misalign;

   // Fetch FSM: redirect wins in every state, then request/response/stall handling.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_REQ;
         r_pc       <= BASEADDR;
         r_drop     <= 1'b0;
         r_insn     <= NOP;
         r_pcout    <= BASEADDR;
         r_valid    <= 1'b0;
         r_flush    <= 1'b0;
         r_misalign <= 1'b0;
      end else begin
         // Status pulses last exactly one cycle after the redirect.
         r_flush    <= w_redirect;
         r_misalign <= w_redirect & w_target_misaligned;
         case (r_state)
            S_REQ: begin
               if (w_redirect) begin
                  r_pc    <= w_target_aligned;
                  r_valid <= 1'b0;
                  r_insn  <= NOP;
                  if (imem_req_ready_i) begin
                     // The old address was accepted; its response is wrong-path.
                     r_state <= S_WAIT;
                     r_drop  <= 1'b1;
                  end else begin
                     r_state <= S_REQ;
                  end
               end else if (imem_req_ready_i) begin
                  r_state <= S_WAIT;
               end else begin
                  r_state <= S_REQ;
               end
            end
            S_WAIT: begin
               if (w_redirect) begin
                  r_pc    <= w_target_aligned;
                  r_valid <= 1'b0;
                  r_insn  <= NOP;
                  if (imem_rsp_valid_i) begin
                     // Response retires the outstanding request; refetch at target.
                     r_drop  <= 1'b0;
                     r_state <= S_REQ;
                  end else begin
                     r_drop  <= 1'b1;
                     r_state <= S_WAIT;
                  end
               end else if (imem_rsp_valid_i) begin
                  if (r_drop) begin
                     r_drop  <= 1'b0;
                     r_state <= S_REQ;
                  end else begin
                     r_insn  <= imem_rsp_data_i;
                     r_pcout <= r_pc;
                     r_valid <= 1'b1;
                     r_pc    <= r_pc + AWIDTH'(4);
                     r_state <= S_HOLD;
                  end
               end else begin
                  r_state <= S_WAIT;
               end
            end
            S_HOLD: begin
               if (w_redirect) begin
                  r_pc    <= w_target_aligned;
                  r_valid <= 1'b0;
                  r_insn  <= NOP;
                  r_state <= S_REQ;
               end else if (!stall_i) begin
                  r_valid <= 1'b0;
                  r_insn  <= NOP;
                  r_state <= S_REQ;
               end else begin
                  r_state <= S_HOLD;
               end
            end
            default: begin
               r_state <= S_REQ;
               r_drop  <= 1'b0;
               r_valid <= 1'b0;
               r_insn  <= NOP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: each task drives one scenario cycle by
// cycle and compares outputs against hand-computed values.
module tb_fetch_unit;

   localparam logic [31:0] BASE = 32'h0100_0000;
   localparam logic [31:0] NOPW = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic        brtaken_i;
   logic        jump_i;
   logic [31:0] target_i;
   logic        stall_i;
   logic        imem_req_valid_o;
   logic [31:0] imem_req_addr_o;
   logic        imem_req_ready_i;
   logic        imem_rsp_valid_i;
   logic [31:0] imem_rsp_data_i;
   logic [31:0] pc_o;
   logic [31:0] insn_o;
   logic        valid_o;
   logic        flush_o;
   logic        misalign_o;

   int errors;
   int checks;

   fetch_unit dut (
      .clk              (clk),
      .reset            (reset),
      .brtaken_i        (brtaken_i),
      .jump_i           (jump_i),
      .target_i         (target_i),
      .stall_i          (stall_i),
      .imem_req_valid_o (imem_req_valid_o),
      .imem_req_addr_o  (imem_req_addr_o),
      .imem_req_ready_i (imem_req_ready_i),
      .imem_rsp_valid_i (imem_rsp_valid_i),
      .imem_rsp_data_i  (imem_rsp_data_i),
      .pc_o             (pc_o),
      .insn_o           (insn_o),
      .valid_o          (valid_o),
      .flush_o          (flush_o),
      .misalign_o       (misalign_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, return at the falling edge for sampling/driving.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      brtaken_i = 1'b0; jump_i = 1'b0; target_i = 32'h0;
      stall_i = 1'b0; imem_req_ready_i = 1'b0;
      imem_rsp_valid_i = 1'b0; imem_rsp_data_i = 32'h0;
   endtask

   task automatic test_reset();
      reset = 1'b1; idle_inputs();
      tick(); tick();
      checks++; if (imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid_o); end
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid_o); end
      checks++; if (insn_o !== NOPW) begin errors++; $display("FAIL rst_insn: got %h want %h", insn_o, NOPW); end
      checks++; if (pc_o !== BASE) begin errors++; $display("FAIL rst_pc: got %h want %h", pc_o, BASE); end
      checks++; if ({flush_o, misalign_o} !== 2'b00) begin errors++; $display("FAIL rst_pulses: got %b want 00", {flush_o, misalign_o}); end
      reset = 1'b0;
      #1;
      checks++; if (imem_req_valid_o !== 1'b1) begin errors++; $display("FAIL rst_rel_req: got %b want 1", imem_req_valid_o); end
      checks++; if (imem_req_addr_o !== BASE) begin errors++; $display("FAIL rst_rel_addr: got %h want %h", imem_req_addr_o, BASE); end
   endtask

   task automatic test_fetch_and_stall();
      logic [31:0] pc_hold;
      logic [31:0] insn_hold;
      imem_req_ready_i = 1'b1; tick();
      imem_req_ready_i = 1'b0;
      checks++; if ({imem_req_valid_o, valid_o} !== 2'b00) begin errors++; $display("FAIL wait_state: got %b want 00", {imem_req_valid_o, valid_o}); end
      imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h0000_0093; stall_i = 1'b1; tick();
      imem_rsp_valid_i = 1'b0; imem_rsp_data_i = 32'h0;
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL fetch_valid: got %b want 1", valid_o); end
      checks++; if (pc_o !== BASE) begin errors++; $display("FAIL fetch_pc: got %h want %h", pc_o, BASE); end
      checks++; if (insn_o !== 32'h0000_0093) begin errors++; $display("FAIL fetch_insn: got %h want 00000093", insn_o); end
      pc_hold = 32'h0100_0000; insn_hold = 32'h0000_0093;
      for (int i = 0; i < 5; i++) begin
         // A stray response in HOLD must be ignored.
         imem_rsp_valid_i = (i == 2); imem_rsp_data_i = 32'hBAD0_BAD0;
         tick();
         checks++;
         if (valid_o !== 1'b1 || pc_o !== pc_hold || insn_o !== insn_hold || imem_req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got v=%b pc=%h insn=%h req=%b want v=1 pc=%h insn=%h req=0",
                     i, valid_o, pc_o, insn_o, imem_req_valid_o, pc_hold, insn_hold);
         end
      end
      imem_rsp_valid_i = 1'b0;
      stall_i = 1'b0; tick();
      checks++; if ({valid_o, insn_o} !== {1'b0, NOPW}) begin errors++; $display("FAIL consume: got v=%b insn=%h want v=0 insn=%h", valid_o, insn_o, NOPW); end
      checks++; if ({imem_req_valid_o, imem_req_addr_o} !== {1'b1, 32'h0100_0004}) begin errors++; $display("FAIL next_req: got v=%b a=%h want v=1 a=01000004", imem_req_valid_o, imem_req_addr_o); end
   endtask

   task automatic test_redirect_in_wait();
      imem_req_ready_i = 1'b1; tick();
      imem_req_ready_i = 1'b0;
      brtaken_i = 1'b1; target_i = 32'h0100_0040; tick();
      brtaken_i = 1'b0; target_i = 32'h0;
      checks++; if ({flush_o, misalign_o, imem_req_valid_o} !== 3'b100) begin errors++; $display("FAIL wredir_pulse: got %b want 100", {flush_o, misalign_o, imem_req_valid_o}); end
      tick();
      checks++; if ({flush_o, imem_req_valid_o} !== 2'b00) begin errors++; $display("FAIL wredir_flush_once: got %b want 00", {flush_o, imem_req_valid_o}); end
      imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'hDEAD_BEEF; tick();
      imem_rsp_valid_i = 1'b0;
      checks++; if ({valid_o, flush_o} !== 2'b00) begin errors++; $display("FAIL wredir_drop: got v=%b f=%b want 0 0", valid_o, flush_o); end
      checks++; if ({imem_req_valid_o, imem_req_addr_o} !== {1'b1, 32'h0100_0040}) begin errors++; $display("FAIL wredir_addr: got v=%b a=%h want v=1 a=01000040", imem_req_valid_o, imem_req_addr_o); end
   endtask

   task automatic test_jump_with_rsp();
      imem_req_ready_i = 1'b1; tick();
      imem_req_ready_i = 1'b0;
      jump_i = 1'b1; target_i = 32'h0100_0080;
      imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h0000_1234; tick();
      jump_i = 1'b0; imem_rsp_valid_i = 1'b0;
      checks++; if ({valid_o, flush_o} !== 2'b01) begin errors++; $display("FAIL jrsp_nov: got v=%b f=%b want 0 1", valid_o, flush_o); end
      checks++; if ({imem_req_valid_o, imem_req_addr_o} !== {1'b1, 32'h0100_0080}) begin errors++; $display("FAIL jrsp_addr: got v=%b a=%h want v=1 a=01000080", imem_req_valid_o, imem_req_addr_o); end
   endtask

   task automatic test_misalign();
      brtaken_i = 1'b1; target_i = 32'h0100_0042; tick();
      brtaken_i = 1'b0;
      checks++; if ({misalign_o, flush_o} !== 2'b11) begin errors++; $display("FAIL mis_pulse: got %b want 11", {misalign_o, flush_o}); end
      checks++; if (imem_req_addr_o !== 32'h0100_0040) begin errors++; $display("FAIL mis_addr: got %h want 01000040", imem_req_addr_o); end
      tick();
      checks++; if ({misalign_o, flush_o} !== 2'b00) begin errors++; $display("FAIL mis_once: got %b want 00", {misalign_o, flush_o}); end
      checks++; if ({imem_req_valid_o, imem_req_addr_o} !== {1'b1, 32'h0100_0040}) begin errors++; $display("FAIL mis_addr_hold: got v=%b a=%h want v=1 a=01000040", imem_req_valid_o, imem_req_addr_o); end
   endtask

   task automatic test_accept_with_redirect();
      imem_req_ready_i = 1'b1; jump_i = 1'b1; target_i = 32'h0100_0100; tick();
      imem_req_ready_i = 1'b0; jump_i = 1'b0;
      checks++; if (imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL acc_redir_wait: got %b want 0", imem_req_valid_o); end
      imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h5555_5555; tick();
      imem_rsp_valid_i = 1'b0;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL acc_redir_drop: got %b want 0", valid_o); end
      checks++; if ({imem_req_valid_o, imem_req_addr_o} !== {1'b1, 32'h0100_0100}) begin errors++; $display("FAIL acc_redir_addr: got v=%b a=%h want v=1 a=01000100", imem_req_valid_o, imem_req_addr_o); end
   endtask

   task automatic test_wrap_and_reset();
      brtaken_i = 1'b1; target_i = 32'hFFFF_FFFC; tick();
      brtaken_i = 1'b0;
      checks++; if (imem_req_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_tgt: got %h want fffffffc", imem_req_addr_o); end
      imem_req_ready_i = 1'b1; tick();
      imem_req_ready_i = 1'b0;
      imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h00A0_0093; tick();
      imem_rsp_valid_i = 1'b0;
      checks++; if ({valid_o, pc_o, insn_o} !== {1'b1, 32'hFFFF_FFFC, 32'h00A0_0093}) begin errors++; $display("FAIL wrap_fetch: got v=%b pc=%h insn=%h want 1 fffffffc 00a00093", valid_o, pc_o, insn_o); end
      tick();
      checks++; if ({imem_req_valid_o, imem_req_addr_o} !== {1'b1, 32'h0000_0000}) begin errors++; $display("FAIL wrap_addr: got v=%b a=%h want v=1 a=00000000", imem_req_valid_o, imem_req_addr_o); end
      imem_req_ready_i = 1'b1; tick();
      imem_req_ready_i = 1'b0;
      reset = 1'b1; tick();
      checks++; if ({imem_req_valid_o, valid_o, flush_o, misalign_o} !== 4'b0000) begin errors++; $display("FAIL wrst_flags: got %b want 0000", {imem_req_valid_o, valid_o, flush_o, misalign_o}); end
      checks++; if ({pc_o, insn_o} !== {BASE, NOPW}) begin errors++; $display("FAIL wrst_regs: got pc=%h insn=%h want %h %h", pc_o, insn_o, BASE, NOPW); end
      reset = 1'b0; #1;
      checks++; if ({imem_req_valid_o, imem_req_addr_o} !== {1'b1, BASE}) begin errors++; $display("FAIL wrst_req: got v=%b a=%h want v=1 a=%h", imem_req_valid_o, imem_req_addr_o, BASE); end
   endtask

   task automatic test_back_to_back();
      // Zero-wait memory: one instruction every three cycles.
      logic [2:0]  exp_valid [6];
      logic [31:0] exp_pc    [6];
      exp_valid = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      exp_pc    = '{BASE, BASE, BASE, BASE, BASE + 32'd4, BASE + 32'd4};
      @(negedge clk);
      imem_req_ready_i = 1'b1; imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h0010_0093;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (valid_o !== exp_valid[i][0] || pc_o !== exp_pc[i]) begin
            errors++;
            $display("FAIL b2b[%0d]: got v=%b pc=%h want v=%b pc=%h", i, valid_o, pc_o, exp_valid[i][0], exp_pc[i]);
         end
      end
      checks++; if ({imem_req_valid_o, imem_req_addr_o} !== {1'b1, BASE + 32'd8}) begin errors++; $display("FAIL b2b_addr: got v=%b a=%h want v=1 a=%h", imem_req_valid_o, imem_req_addr_o, BASE + 32'd8); end
      idle_inputs();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_fetch_and_stall();
      test_redirect_in_wait();
      test_jump_with_rsp();
      test_misalign();
      test_accept_with_redirect();
      test_wrap_and_reset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch stage that consumes the execute stage's resolved control flow (branch-taken flag plus target address) and turns it into instruction-memory requests.
- Holds the architectural PC and issues one outstanding instruction-memory request at a time over a valid/ready request channel and a valid-only response channel.
- Presents the fetched instruction and its PC to decode.
- Squashes wrong-path fetches when execute redirects.

Parameters:
- AWIDTH, 32, address/PC width.
- DWIDTH, 32, instruction word width.
- BASEADDR, 32'h0100_0000, PC value after reset.
- NOP, 32'h0000_0013, value driven on insn_o when no instruction is valid (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- brtaken_i  input  1  conditional branch resolved taken in execute.
- jump_i  input  1  JAL/JALR in execute; unconditional redirect.
- target_i  input  AWIDTH  redirect target from execute; valid when brtaken_i or jump_i is 1.
- stall_i  input  1  decode cannot accept the held instruction.
- imem_req_valid_o  output  1  request valid.
- imem_req_addr_o  output  AWIDTH  request word address.
- imem_req_ready_i  input  1  memory accepts the request this cycle.
- imem_rsp_valid_i  input  1  response data valid.
- imem_rsp_data_i  input  DWIDTH  instruction word.
- pc_o  output  AWIDTH  PC of insn_o.
- insn_o  output  DWIDTH  fetched instruction.
- valid_o  output  1  insn_o/pc_o are valid for decode.
- flush_o  output  1  one-cycle pulse telling decode to squash its contents.
- misalign_o  output  1  one-cycle pulse: redirect target had bits [1:0] != 0.

Behaviour:
- Registers: pc_q, state, drop_q, insn_q, pcout_q, valid_q, flush_q, misalign_q.
- All outputs are registered except imem_req_valid_o and imem_req_addr_o, which decode from state and pc_q.
- Reset (sampled at clk edge):
  - pc_q = BASEADDR; state = REQ; drop_q = 0.
  - valid_o = 0; insn_o = NOP; pc_o = BASEADDR; flush_o = 0; misalign_o = 0.
  - imem_req_valid_o is 0 during the reset cycle.
  - Reset mid-transaction discards everything. The memory shares the same reset, so no stale response follows reset.
- redirect = brtaken_i | jump_i. Redirect has the highest priority in every state and overrides stall_i.
- On redirect:
  - pc_q <= {target_i[AWIDTH-1:2], 2'b00}.
  - flush_o = 1 in the next cycle only.
  - misalign_o = 1 in the next cycle only if target_i[1:0] != 0.
  - valid_o <= 0.
- States:
  - REQ: imem_req_valid_o = 1, imem_req_addr_o = pc_q.
    - Accepted (ready_i = 1) with no redirect -> WAIT.
    - Accepted in the same cycle as a redirect -> WAIT with drop_q <= 1.
    - Redirect while not accepted -> stay in REQ; the address changes to the new pc_q next cycle. This is the only case where the address may change before acceptance.
    - Otherwise the address is held stable until accepted.
  - WAIT: imem_req_valid_o = 0.
    - rsp_valid_i with drop_q = 1 -> drop the data, clear drop_q, go to REQ (pc_q already holds the target).
    - rsp_valid_i with drop_q = 0 and no redirect -> insn_o <= data, pc_o <= pc_q, valid_o <= 1, pc_q <= pc_q + 4, go to HOLD.
    - rsp_valid_i and redirect in the same cycle -> drop the data, go to REQ at the target.
    - Redirect without rsp_valid_i -> drop_q <= 1, stay in WAIT.
  - HOLD: valid_o = 1; insn_o and pc_o held stable.
    - stall_i = 0 -> the instruction is consumed this cycle; next cycle valid_o = 0, insn_o = NOP, state = REQ.
    - stall_i = 1 -> hold.
    - Redirect -> REQ at the target, valid_o <= 0.
- stall_i is ignored in REQ and WAIT.
- imem_rsp_valid_i outside WAIT is ignored.
- pc_q + 4 wraps modulo 2^AWIDTH (0xFFFF_FFFC -> 0x0000_0000).
- Minimum latency, request accepted to valid_o: 1 cycle after rsp_valid_i. Steady-state throughput with zero-wait memory: 1 instruction per 3 cycles (REQ, WAIT, HOLD).

Test Plan:
- Reset release; ready_i = 1; response 1 cycle later with 32'h0000_0093 -> req_addr = 0x0100_0000; then valid_o = 1, pc_o = 0x0100_0000, insn_o = 0x93; next request addr = 0x0100_0004.
- Hold stall_i = 1 for 5 cycles in HOLD -> valid_o, insn_o and pc_o stable; no new request; stall_i drops -> request 0x0100_0004 next cycle.
- brtaken_i = 1, target_i = 0x0100_0040 while in WAIT; response arrives 2 cycles later -> response dropped (valid_o stays 0), flush_o pulses once, next request addr = 0x0100_0040.
- jump_i = 1 in the same cycle as rsp_valid_i -> no valid_o; next request addr = target.
- Redirect to 0x0100_0042 -> misalign_o pulses once; next request addr = 0x0100_0040.
- pc_q = 0xFFFF_FFFC fetched and consumed -> next request addr = 0x0000_0000; assert reset while in WAIT -> all outputs return to their reset values and the next request is 0x0100_0000.
